// File: rtl/expr_eval_if.sv
// rtl/expr_eval_if.sv - character stream in, evaluated value and status out
// master drives characters, slave (the evaluator) drives result/ok/err.
interface expr_eval_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       in;
  logic             in_valid;
  logic [WIDTH-1:0] result;
  logic             ok;
  logic             err;

  modport master (output in, output in_valid, input result, input ok, input err);
  modport slave  (input in, input in_valid, output result, output ok, output err);
endinterface

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - incremental evaluator for digit/'+'/'*' ASCII expressions
// Optional macro EXPR_EVAL_MULTI_DIGIT_EN enables multi-digit decimal operands.
module expr_eval #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        clr,
  expr_eval_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NUM  = 2'd1,
    ST_OP   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             is_digit;
  logic             is_plus;
  logic             is_star;
  logic [WIDTH-1:0] digit_val;
  logic [7:0]       digit_off;

  assign is_digit  = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign is_plus   = (bus.in == 8'h2b);
  assign is_star   = (bus.in == 8'h2a);
  assign digit_off = bus.in - 8'h30;
  assign digit_val = WIDTH'(digit_off);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      sum_q    <= '0;
      prod_q   <= WIDTH'(1);
      cur_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      prod_q   <= prod_d;
      cur_q    <= cur_d;
      result_q <= result_d;
    end
  end

  // result is only refreshed on edges landing in NUM, so it always shows
  // the value of the longest prefix that ends in a digit.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    prod_d   = prod_q;
    cur_d    = cur_q;
    result_d = result_q;
    if (bus.in_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_digit) begin
            state_d  = ST_NUM;
            cur_d    = digit_val;
            prod_d   = WIDTH'(1);
            sum_d    = '0;
            result_d = digit_val;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_NUM: begin
          if (is_star) begin
            state_d = ST_OP;
            prod_d  = prod_q * cur_q;
            cur_d   = '0;
          end else if (is_plus) begin
            state_d = ST_OP;
            sum_d   = sum_q + prod_q * cur_q;
            prod_d  = WIDTH'(1);
            cur_d   = '0;
          end else if (is_digit) begin
`ifdef EXPR_EVAL_MULTI_DIGIT_EN
            cur_d    = cur_q * WIDTH'(10) + digit_val;
            result_d = sum_q + prod_q * cur_d;
`else
            state_d = ST_ERR;
`endif
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_OP: begin
          if (is_digit) begin
            state_d  = ST_NUM;
            cur_d    = digit_val;
            result_d = sum_q + prod_q * digit_val;
          end else begin
            state_d = ST_ERR;
          end
        end
        default: state_d = ST_ERR;
      endcase
    end
  end

  always_comb begin
    bus.result = result_q;
    bus.ok     = (state_q == ST_NUM);
    bus.err    = (state_q == ST_ERR);
  end

endmodule
